// File: rtl/cpu_fetch_decode.sv
// Micro CPU front end: fetches opcode/operand byte pairs, decodes them and issues to execute.
// Define CPU_ILLEGAL_TRAP_EN to halt with a sticky illegal flag on an undefined opcode.
module cpu_fetch_decode #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned RESET_PC   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] pmem_addr,
   output logic                  pmem_rd,
   input  logic [DATA_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_rvalid,
   output logic                  dec_valid,
   input  logic                  dec_ready,
   output logic [3:0]            dec_op,
   output logic                  dec_imm,
   output logic                  dec_carry,
   output logic [DATA_WIDTH-1:0] dec_operand,
   output logic [ADDR_WIDTH-1:0] dec_pc,
   input  logic                  br_resolve,
   input  logic                  br_taken,
   input  logic [ADDR_WIDTH-1:0] br_target,
   output logic                  illegal
);

   localparam int unsigned OPC_WIDTH = 8;
   localparam logic [ADDR_WIDTH-1:0] PC_RST = ADDR_WIDTH'(RESET_PC);

   typedef enum logic [3:0] {
      OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_NOR, OP_NAND, OP_XOR, OP_XNOR,
      OP_JUMP, OP_JZ, OP_JC, OP_JN
   } operation_e;

   typedef enum logic [2:0] {
      FETCH_OP, WAIT_OP, FETCH_ARG, WAIT_ARG, ISSUE, WAIT_BR
`ifdef CPU_ILLEGAL_TRAP_EN
      , HALT
`endif
   } state_e;

   state_e                 state;
   logic [ADDR_WIDTH-1:0]  pc;
   logic [OPC_WIDTH-1:0]   opcode;
   logic [ADDR_WIDTH-1:0]  pc_inc1;
   logic [ADDR_WIDTH-1:0]  pc_inc2;
   logic [ADDR_WIDTH-1:0]  br_next;
   operation_e             d_op;
   logic                   d_legal;
   logic                   d_imm;
   logic                   d_carry;

   assign pc_inc1 = pc + ADDR_WIDTH'(1);
   assign pc_inc2 = pc + ADDR_WIDTH'(2);
   assign br_next = br_taken ? br_target : pc_inc2;

   // Opcode decode; anything outside the four defined groups is illegal
   always_comb begin
      d_legal = 1'b0;
      d_op    = OP_LOAD;
      d_imm   = 1'b0;
      d_carry = 1'b0;
      case (opcode[7:6])
         2'b00: if (opcode[5:2] == 4'd0) begin
            d_legal = 1'b1;
            d_op    = opcode[0] ? OP_STORE : OP_LOAD;
            d_imm   = opcode[1];
         end
         2'b01: if (opcode[5:3] == 3'd0) begin
            d_legal = 1'b1;
            d_op    = opcode[0] ? OP_SUB : OP_ADD;
            d_carry = opcode[1];
            d_imm   = opcode[2];
         end
         2'b10: if (opcode[5:3] == 3'd0) begin
            d_legal = 1'b1;
            d_imm   = opcode[2];
            case (opcode[1:0])
               2'b00:   d_op = OP_NOR;
               2'b01:   d_op = OP_NAND;
               2'b10:   d_op = OP_XOR;
               default: d_op = OP_XNOR;
            endcase
         end
         default: if (opcode[5:2] == 4'd0) begin
            d_legal = 1'b1;
            case (opcode[1:0])
               2'b00:   d_op = OP_JUMP;
               2'b01:   d_op = OP_JZ;
               2'b10:   d_op = OP_JC;
               default: d_op = OP_JN;
            endcase
         end
      endcase
   end

`ifndef CPU_ILLEGAL_TRAP_EN
   assign illegal = 1'b0;
`endif

   // Fetch/issue FSM; the read strobe is raised on the edge that enters FETCH_OP/FETCH_ARG
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= FETCH_OP;
         pc          <= PC_RST;
         opcode      <= '0;
         pmem_addr   <= PC_RST;
         pmem_rd     <= 1'b0;
         dec_valid   <= 1'b0;
         dec_op      <= 4'd0;
         dec_imm     <= 1'b0;
         dec_carry   <= 1'b0;
         dec_operand <= '0;
         dec_pc      <= '0;
`ifdef CPU_ILLEGAL_TRAP_EN
         illegal     <= 1'b0;
`endif
      end else begin
         pmem_rd <= 1'b0;
         case (state)
            // Only the first fetch after reset arrives here without a strobe already out
            FETCH_OP: begin
               if (!pmem_rd) begin
                  pmem_rd   <= 1'b1;
                  pmem_addr <= pc;
               end else begin
                  state <= WAIT_OP;
               end
            end
            WAIT_OP: if (pmem_rvalid) begin
               opcode    <= pmem_rdata[OPC_WIDTH-1:0];
               pmem_rd   <= 1'b1;
               pmem_addr <= pc_inc1;
               state     <= FETCH_ARG;
            end
            FETCH_ARG: state <= WAIT_ARG;
            WAIT_ARG: if (pmem_rvalid) begin
               if (d_legal) begin
                  dec_valid   <= 1'b1;
                  dec_op      <= d_op;
                  dec_imm     <= d_imm;
                  dec_carry   <= d_carry;
                  dec_operand <= pmem_rdata;
                  dec_pc      <= pc;
                  state       <= ISSUE;
               end else begin
`ifdef CPU_ILLEGAL_TRAP_EN
                  illegal <= 1'b1;
                  dec_pc  <= pc;
                  state   <= HALT;
`else
                  pc        <= pc_inc2;
                  pmem_rd   <= 1'b1;
                  pmem_addr <= pc_inc2;
                  state     <= FETCH_OP;
`endif
               end
            end
            ISSUE: if (dec_ready) begin
               dec_valid <= 1'b0;
               if (opcode[7:6] == 2'b11) begin
                  state <= WAIT_BR;
               end else begin
                  pc        <= pc_inc2;
                  pmem_rd   <= 1'b1;
                  pmem_addr <= pc_inc2;
                  state     <= FETCH_OP;
               end
            end
            WAIT_BR: if (br_resolve) begin
               pc        <= br_next;
               pmem_rd   <= 1'b1;
               pmem_addr <= br_next;
               state     <= FETCH_OP;
            end
`ifdef CPU_ILLEGAL_TRAP_EN
            HALT: state <= HALT;
`endif
            default: state <= FETCH_OP;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_fetch_decode.sv
// Directed bench for cpu_fetch_decode: reset, backpressure, jumps, PC wrap, illegal opcode, async reset.
module tb_cpu_fetch_decode;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 8;
   localparam logic [3:0] OP_LOAD  = 4'd0;
   localparam logic [3:0] OP_STORE = 4'd1;
   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_XNOR  = 4'd7;
   localparam logic [3:0] OP_JUMP  = 4'd8;
   localparam logic [3:0] OP_JZ    = 4'd9;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [AW-1:0] pmem_addr;
   logic          pmem_rd;
   logic [DW-1:0] pmem_rdata;
   logic          pmem_rvalid;
   logic          dec_valid;
   logic          dec_ready = 1'b1;
   logic [3:0]    dec_op;
   logic          dec_imm;
   logic          dec_carry;
   logic [DW-1:0] dec_operand;
   logic [AW-1:0] dec_pc;
   logic          br_resolve = 1'b0;
   logic          br_taken = 1'b0;
   logic [AW-1:0] br_target = '0;
   logic          illegal;

   logic [7:0]    mem [256];
   logic          model_rvalid = 1'b0;
   logic [7:0]    model_rdata = '0;
   logic          mem_auto = 1'b1;
   logic          man_rvalid = 1'b0;
   logic [7:0]    man_rdata = '0;

   int checks = 0;
   int errors = 0;

   cpu_fetch_decode #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .pmem_addr(pmem_addr), .pmem_rd(pmem_rd), .pmem_rdata(pmem_rdata), .pmem_rvalid(pmem_rvalid),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op), .dec_imm(dec_imm),
      .dec_carry(dec_carry), .dec_operand(dec_operand), .dec_pc(dec_pc),
      .br_resolve(br_resolve), .br_taken(br_taken), .br_target(br_target), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // One-cycle-latency program memory, bypassable for hand-driven responses
   always @(posedge clk) begin
      model_rvalid <= pmem_rd;
      model_rdata  <= mem[pmem_addr];
   end
   assign pmem_rvalid = mem_auto ? model_rvalid : man_rvalid;
   assign pmem_rdata  = mem_auto ? model_rdata  : man_rdata;

   task automatic run_to_valid(input logic [7:0] pc, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (dec_valid === 1'b1 && dec_pc === pc) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (pmem_rd !== 1'b0 || pmem_addr !== 8'h10 || dec_valid !== 1'b0) begin
         errors++; $display("FAIL reset_fetch: rd=%b addr=%h valid=%b, required 0 10 0", pmem_rd, pmem_addr, dec_valid);
      end
      checks++;
      if (dec_op !== 4'd0 || dec_imm !== 1'b0 || dec_carry !== 1'b0 || dec_operand !== 8'h00 || dec_pc !== 8'h00 || illegal !== 1'b0) begin
         errors++; $display("FAIL reset_dec: op=%0d imm=%b carry=%b operand=%h pc=%h illegal=%b, required all 0", dec_op, dec_imm, dec_carry, dec_operand, dec_pc, illegal);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (pmem_rd !== 1'b1 || pmem_addr !== 8'h10) begin
         errors++; $display("FAIL reset_op_read: rd=%b addr=%h, required 1 10", pmem_rd, pmem_addr);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (pmem_rd !== 1'b1 || pmem_addr !== 8'h11) begin
         errors++; $display("FAIL reset_arg_read: rd=%b addr=%h, required 1 11", pmem_rd, pmem_addr);
      end
      @(negedge clk);
      checks++;
      if (dec_valid !== 1'b0) begin
         errors++; $display("FAIL reset_early_valid: valid=%b, required 0", dec_valid);
      end
      @(negedge clk);
      checks++;
      if (dec_valid !== 1'b1 || dec_op !== OP_ADD || dec_imm !== 1'b1 || dec_carry !== 1'b0 || dec_operand !== 8'h05 || dec_pc !== 8'h10) begin
         errors++; $display("FAIL reset_issue: valid=%b op=%0d imm=%b carry=%b operand=%h pc=%h, required 1 2 1 0 05 10", dec_valid, dec_op, dec_imm, dec_carry, dec_operand, dec_pc);
      end
      @(negedge clk);
      checks++;
      if (pmem_rd !== 1'b1 || pmem_addr !== 8'h12 || dec_valid !== 1'b0) begin
         errors++; $display("FAIL reset_next_read: rd=%b addr=%h valid=%b, required 1 12 0", pmem_rd, pmem_addr, dec_valid);
      end
   endtask

   task automatic test_backpressure();
      bit found = 1'b0;
      dec_ready = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (dec_valid === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found || dec_pc !== 8'h12) begin
         errors++; $display("FAIL bp_issue: found=%b pc=%h, required 1 12", found, dec_pc);
      end
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if (dec_valid !== 1'b1 || dec_op !== OP_XNOR || dec_operand !== 8'h22 || dec_imm !== 1'b0 || pmem_rd !== 1'b0) begin
            errors++; $display("FAIL bp_hold cycle %0d: valid=%b op=%0d operand=%h imm=%b rd=%b, required 1 7 22 0 0", i, dec_valid, dec_op, dec_operand, dec_imm, pmem_rd);
         end
      end
      dec_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (pmem_rd !== 1'b1 || pmem_addr !== 8'h14 || dec_valid !== 1'b0) begin
         errors++; $display("FAIL bp_release: rd=%b addr=%h valid=%b, required 1 14 0", pmem_rd, pmem_addr, dec_valid);
      end
   endtask

   task automatic test_jump_taken();
      bit ok;
      bit saw_rd = 1'b0;
      run_to_valid(8'h20, 60, ok);
      checks++;
      if (!ok || dec_op !== OP_JZ || dec_operand !== 8'h40 || dec_imm !== 1'b0 || dec_carry !== 1'b0) begin
         errors++; $display("FAIL jt_issue: found=%b op=%0d operand=%h imm=%b carry=%b, required 1 9 40 0 0", ok, dec_op, dec_operand, dec_imm, dec_carry);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (pmem_rd !== 1'b0) saw_rd = 1'b1;
      end
      checks++;
      if (saw_rd) begin
         errors++; $display("FAIL jt_wait_br_fetch: read seen=%b, required 0", saw_rd);
      end
      br_resolve = 1'b1; br_taken = 1'b1; br_target = 8'h40;
      @(negedge clk);
      br_resolve = 1'b0; br_taken = 1'b0; br_target = 8'h00;
      checks++;
      if (pmem_rd !== 1'b1 || pmem_addr !== 8'h40) begin
         errors++; $display("FAIL jt_redirect: rd=%b addr=%h, required 1 40", pmem_rd, pmem_addr);
      end
      // stray resolve while fetching; the next test expects pc to stay at 0x40
      @(negedge clk);
      br_resolve = 1'b1; br_taken = 1'b1; br_target = 8'h77;
      @(negedge clk);
      br_resolve = 1'b0; br_taken = 1'b0; br_target = 8'h00;
   endtask

   task automatic test_jump_not_taken();
      bit ok;
      bit saw_rd = 1'b0;
      run_to_valid(8'h40, 20, ok);
      checks++;
      if (!ok || dec_op !== OP_JZ || dec_operand !== 8'h40) begin
         errors++; $display("FAIL jn_issue: found=%b op=%0d operand=%h, required 1 9 40", ok, dec_op, dec_operand);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (pmem_rd !== 1'b0) saw_rd = 1'b1;
      end
      checks++;
      if (saw_rd) begin
         errors++; $display("FAIL jn_wait_br_fetch: read seen=%b, required 0", saw_rd);
      end
      br_resolve = 1'b1; br_taken = 1'b0; br_target = 8'h99;
      @(negedge clk);
      br_resolve = 1'b0; br_target = 8'h00;
      checks++;
      if (pmem_rd !== 1'b1 || pmem_addr !== 8'h42) begin
         errors++; $display("FAIL jn_fallthrough: rd=%b addr=%h, required 1 42", pmem_rd, pmem_addr);
      end
   endtask

   task automatic test_wrap();
      bit ok;
      run_to_valid(8'h42, 20, ok);
      checks++;
      if (!ok || dec_op !== OP_JUMP) begin
         errors++; $display("FAIL wrap_jump_issue: found=%b op=%0d, required 1 8", ok, dec_op);
      end
      @(negedge clk);
      br_resolve = 1'b1; br_taken = 1'b1; br_target = 8'hFF;
      @(negedge clk);
      br_resolve = 1'b0; br_taken = 1'b0; br_target = 8'h00;
      checks++;
      if (pmem_rd !== 1'b1 || pmem_addr !== 8'hFF) begin
         errors++; $display("FAIL wrap_op_read: rd=%b addr=%h, required 1 ff", pmem_rd, pmem_addr);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (pmem_rd !== 1'b1 || pmem_addr !== 8'h00) begin
         errors++; $display("FAIL wrap_arg_read: rd=%b addr=%h, required 1 00", pmem_rd, pmem_addr);
      end
      run_to_valid(8'hFF, 5, ok);
      checks++;
      if (!ok || dec_op !== OP_STORE || dec_imm !== 1'b0 || dec_carry !== 1'b0 || dec_operand !== 8'h7E) begin
         errors++; $display("FAIL wrap_issue: found=%b op=%0d imm=%b carry=%b operand=%h, required 1 1 0 0 7e", ok, dec_op, dec_imm, dec_carry, dec_operand);
      end
      @(negedge clk);
      checks++;
      if (pmem_rd !== 1'b1 || pmem_addr !== 8'h01) begin
         errors++; $display("FAIL wrap_next_read: rd=%b addr=%h, required 1 01", pmem_rd, pmem_addr);
      end
   endtask

   task automatic test_illegal();
      bit ok;
      bit saw_valid;
      run_to_valid(8'h01, 10, ok);
      checks++;
      if (!ok || dec_op !== OP_JUMP) begin
         errors++; $display("FAIL ill_jump_issue: found=%b op=%0d, required 1 8", ok, dec_op);
      end
      @(negedge clk);
      br_resolve = 1'b1; br_taken = 1'b1; br_target = 8'h30;
      @(negedge clk);
      br_resolve = 1'b0; br_taken = 1'b0; br_target = 8'h00;
      checks++;
      if (pmem_rd !== 1'b1 || pmem_addr !== 8'h30) begin
         errors++; $display("FAIL ill_op_read: rd=%b addr=%h, required 1 30", pmem_rd, pmem_addr);
      end
      saw_valid = (dec_valid !== 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i < 3 && dec_valid !== 1'b0) saw_valid = 1'b1;
         if (i == 1) begin
            checks++;
            if (pmem_rd !== 1'b1 || pmem_addr !== 8'h31) begin
               errors++; $display("FAIL ill_arg_read: rd=%b addr=%h, required 1 31", pmem_rd, pmem_addr);
            end
         end
      end
`ifdef CPU_ILLEGAL_TRAP_EN
      checks++;
      if (illegal !== 1'b1 || dec_pc !== 8'h30 || dec_valid !== 1'b0 || saw_valid) begin
         errors++; $display("FAIL ill_trap: illegal=%b pc=%h valid=%b earlier_valid=%b, required 1 30 0 0", illegal, dec_pc, dec_valid, saw_valid);
      end
      begin
         bit saw_rd = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pmem_rd !== 1'b0 || illegal !== 1'b1) saw_rd = 1'b1;
         end
         checks++;
         if (saw_rd) begin
            errors++; $display("FAIL ill_halt: read or illegal drop seen=%b, required 0", saw_rd);
         end
      end
`else
      checks++;
      if (pmem_rd !== 1'b1 || pmem_addr !== 8'h32) begin
         errors++; $display("FAIL ill_skip_read: rd=%b addr=%h, required 1 32", pmem_rd, pmem_addr);
      end
      checks++;
      if (saw_valid || dec_valid !== 1'b0 || illegal !== 1'b0) begin
         errors++; $display("FAIL ill_skip_silent: earlier_valid=%b valid=%b illegal=%b, required 0 0 0", saw_valid, dec_valid, illegal);
      end
`endif
   endtask

   task automatic test_async_reset();
      bit ok;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_to_valid(8'h10, 12, ok);
      checks++;
      if (!ok || dec_op !== OP_ADD) begin
         errors++; $display("FAIL ar_first_issue: found=%b op=%0d, required 1 2", ok, dec_op);
      end
      mem_auto = 1'b0; man_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if (pmem_rd !== 1'b1 || pmem_addr !== 8'h12) begin
         errors++; $display("FAIL ar_op_read: rd=%b addr=%h, required 1 12", pmem_rd, pmem_addr);
      end
      @(negedge clk);
      man_rvalid = 1'b1; man_rdata = 8'h83;
      @(negedge clk);
      man_rvalid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (pmem_rd !== 1'b0 || pmem_addr !== 8'h10 || dec_valid !== 1'b0 || dec_op !== 4'd0 || dec_imm !== 1'b0 || dec_operand !== 8'h00 || dec_pc !== 8'h00 || illegal !== 1'b0) begin
         errors++; $display("FAIL ar_immediate: rd=%b addr=%h valid=%b op=%0d imm=%b operand=%h pc=%h illegal=%b, required 0 10 0 0 0 00 00 0", pmem_rd, pmem_addr, dec_valid, dec_op, dec_imm, dec_operand, dec_pc, illegal);
      end
      @(negedge clk);
      rst_n = 1'b1;
      man_rvalid = 1'b1; man_rdata = 8'hC3;
      @(negedge clk);
      man_rvalid = 1'b0;
      checks++;
      if (pmem_rd !== 1'b1 || pmem_addr !== 8'h10) begin
         errors++; $display("FAIL ar_fresh_fetch: rd=%b addr=%h, required 1 10", pmem_rd, pmem_addr);
      end
      @(negedge clk);
      man_rvalid = 1'b1; man_rdata = 8'h44;
      @(negedge clk);
      man_rvalid = 1'b0;
      checks++;
      if (pmem_rd !== 1'b1 || pmem_addr !== 8'h11) begin
         errors++; $display("FAIL ar_arg_read: rd=%b addr=%h, required 1 11", pmem_rd, pmem_addr);
      end
      @(negedge clk);
      man_rvalid = 1'b1; man_rdata = 8'h05;
      @(negedge clk);
      man_rvalid = 1'b0;
      checks++;
      if (dec_valid !== 1'b1 || dec_op !== OP_ADD || dec_imm !== 1'b1 || dec_operand !== 8'h05 || dec_pc !== 8'h10) begin
         errors++; $display("FAIL ar_issue: valid=%b op=%0d imm=%b operand=%h pc=%h, required 1 2 1 05 10", dec_valid, dec_op, dec_imm, dec_operand, dec_pc);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h10] = 8'h44; mem[8'h11] = 8'h05;
      mem[8'h12] = 8'h83; mem[8'h13] = 8'h22;
      mem[8'h20] = 8'hC1; mem[8'h21] = 8'h40;
      mem[8'h40] = 8'hC1; mem[8'h41] = 8'h40;
      mem[8'h42] = 8'hC0; mem[8'h43] = 8'h00;
      mem[8'hFF] = 8'h01; mem[8'h00] = 8'h7E;
      mem[8'h01] = 8'hC0; mem[8'h02] = 8'h00;
      mem[8'h30] = 8'h48; mem[8'h31] = 8'h00;
      test_reset();
      test_backpressure();
      test_jump_taken();
      test_jump_not_taken();
      test_wrap();
      test_illegal();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
